// File: rtl/pwm_cfg_seq.sv
// Configuration sequencer: reprograms a full PWM profile through the register-file port,
// sharing it with the host (host wins). Readback verify compiled in with PWM_CFG_SEQ_VERIFY_EN.
module pwm_cfg_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [5:0]  host_addr,
  input  logic [7:0]  host_data_write,
  output logic [7:0]  host_data_read,
  input  logic        start,
  input  logic [15:0] cfg_period,
  input  logic [15:0] cfg_compare1,
  input  logic [15:0] cfg_compare2,
  input  logic [7:0]  cfg_prescale,
  input  logic        cfg_upnotdown,
  input  logic [7:0]  cfg_functions,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        read,
  output logic        write,
  output logic [5:0]  addr,
  output logic [7:0]  data_write,
  input  logic [7:0]  data_read
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [7:0]  prescale;
    logic        upnotdown;
    logic [7:0]  functions;
  } cfg_t;

  localparam logic [3:0] LAST_STEP = 4'd13;

  state_t     state, state_n;
  logic [3:0] step, step_n;
  cfg_t       cfg_q;
  logic       host_act;
  logic [5:0] step_addr;
  logic [7:0] step_data;
  logic       verify_step;

  assign host_act       = host_read | host_write;
  assign host_data_read = data_read;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

  // Write list: disable first, load profile, reset counter, re-enable last.
  always_comb begin
    step_addr = 6'h00;
    step_data = 8'h00;
    case (step)
      4'd0:  begin step_addr = 6'h02; step_data = 8'h00; end
      4'd1:  begin step_addr = 6'h0C; step_data = 8'h00; end
      4'd2:  begin step_addr = 6'h00; step_data = cfg_q.period[7:0]; end
      4'd3:  begin step_addr = 6'h01; step_data = cfg_q.period[15:8]; end
      4'd4:  begin step_addr = 6'h03; step_data = cfg_q.compare1[7:0]; end
      4'd5:  begin step_addr = 6'h04; step_data = cfg_q.compare1[15:8]; end
      4'd6:  begin step_addr = 6'h05; step_data = cfg_q.compare2[7:0]; end
      4'd7:  begin step_addr = 6'h06; step_data = cfg_q.compare2[15:8]; end
      4'd8:  begin step_addr = 6'h0A; step_data = cfg_q.prescale; end
      4'd9:  begin step_addr = 6'h0B; step_data = {7'b0, cfg_q.upnotdown}; end
      4'd10: begin step_addr = 6'h0D; step_data = cfg_q.functions; end
      4'd11: begin step_addr = 6'h07; step_data = 8'h01; end
      4'd12: begin step_addr = 6'h0C; step_data = 8'h01; end
      4'd13: begin step_addr = 6'h02; step_data = 8'h01; end
      default: ;
    endcase
  end

`ifdef PWM_CFG_SEQ_VERIFY_EN
  logic err_set;
  // Steps 2..10 are the data registers that get read back.
  assign verify_step = (step >= 4'd2) && (step <= 4'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        error <= 1'b0;
    else if (state == S_IDLE && start) error <= 1'b0;
    else if (err_set)                  error <= 1'b1;
  end
`else
  assign verify_step = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= 4'd0;
      cfg_q <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      if (state == S_IDLE && start)
        cfg_q <= '{cfg_period, cfg_compare1, cfg_compare2, cfg_prescale, cfg_upnotdown, cfg_functions};
    end
  end

  // Sequencer only advances on cycles the host leaves the port free.
  always_comb begin
    state_n = state;
    step_n  = step;
`ifdef PWM_CFG_SEQ_VERIFY_EN
    err_set = 1'b0;
`endif
    case (state)
      S_IDLE: if (start) begin
        state_n = S_WRITE;
        step_n  = 4'd0;
      end
      S_WRITE: if (!host_act) begin
        if (verify_step)             state_n = S_VERIFY;
        else if (step == LAST_STEP)  state_n = S_DONE;
        else                         step_n  = step + 4'd1;
      end
`ifdef PWM_CFG_SEQ_VERIFY_EN
      S_VERIFY: if (!host_act) begin
        if (data_read == step_data) begin
          state_n = S_WRITE;
          step_n  = step + 4'd1;
        end else begin
          err_set = 1'b1;
          state_n = S_DONE;
        end
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    addr       = 6'h00;
    data_write = 8'h00;
    if (host_act) begin
      read       = host_read;
      write      = host_write;
      addr       = host_addr;
      data_write = host_data_write;
    end else if (state == S_WRITE) begin
      write      = 1'b1;
      addr       = step_addr;
      data_write = step_data;
    end
`ifdef PWM_CFG_SEQ_VERIFY_EN
    else if (state == S_VERIFY) begin
      read = 1'b1;
      addr = step_addr;
    end
`endif
  end

endmodule

// File: tb/tb_pwm_cfg_seq.sv
// Directed bench for pwm_cfg_seq with a behavioural register file on the port.
module tb_pwm_cfg_seq;
`ifdef PWM_CFG_SEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int BASE_DONE = VERIFY ? 24 : 15;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        host_read = 0, host_write = 0;
  logic [5:0]  host_addr = 0;
  logic [7:0]  host_data_write = 0, host_data_read;
  logic        start = 0;
  logic [15:0] cfg_period = 0, cfg_compare1 = 0, cfg_compare2 = 0;
  logic [7:0]  cfg_prescale = 0, cfg_functions = 0;
  logic        cfg_upnotdown = 0;
  logic        busy, done, error, read, write;
  logic [5:0]  addr;
  logic [7:0]  data_write, data_read;

  logic [7:0]  regs [64];
  logic        fault = 1'b0;

  int errs = 0, checks = 0;
  logic [5:0] seq_wa[$];
  logic [7:0] seq_wd[$];
  int host_seen, host_ok, done_cnt, done_cyc, wr_at_rst, first_wr_cyc;
  logic busy_after, busy_c1, rst_busy, rst_write;
  logic [5:0] exp_a [14];
  logic [7:0] exp_d [14];

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) regs[i] = 8'h00;
  always @(posedge clk) if (write) regs[addr] <= data_write;
  assign data_read = (fault && read && addr == 6'h03) ? 8'hFF : regs[addr];

  pwm_cfg_seq dut (
    .clk(clk), .rst_n(rst_n),
    .host_read(host_read), .host_write(host_write), .host_addr(host_addr),
    .host_data_write(host_data_write), .host_data_read(host_data_read),
    .start(start), .cfg_period(cfg_period), .cfg_compare1(cfg_compare1),
    .cfg_compare2(cfg_compare2), .cfg_prescale(cfg_prescale),
    .cfg_upnotdown(cfg_upnotdown), .cfg_functions(cfg_functions),
    .busy(busy), .done(done), .error(error), .read(read), .write(write),
    .addr(addr), .data_write(data_write), .data_read(data_read)
  );

  task automatic set_cfg(input logic [15:0] p, c1, c2, input logic [7:0] ps, input logic ud, input logic [7:0] fn);
    cfg_period = p; cfg_compare1 = c1; cfg_compare2 = c2;
    cfg_prescale = ps; cfg_upnotdown = ud; cfg_functions = fn;
    exp_a = '{6'h02, 6'h0C, 6'h00, 6'h01, 6'h03, 6'h04, 6'h05, 6'h06, 6'h0A, 6'h0B, 6'h0D, 6'h07, 6'h0C, 6'h02};
    exp_d = '{8'h00, 8'h00, p[7:0], p[15:8], c1[7:0], c1[15:8], c2[7:0], c2[15:8], ps, {7'b0, ud}, fn, 8'h01, 8'h01, 8'h01};
  endtask

  // Pulses start (sampled at edge 0) then logs cycles 1..ncyc at the negedge.
  task automatic run_seq(input int ncyc, input int h_from, input int h_len, input int re_at, input int rst_at);
    seq_wa.delete(); seq_wd.delete();
    host_seen = 0; host_ok = 0; done_cnt = 0; done_cyc = -1; wr_at_rst = -1; first_wr_cyc = -1;
    busy_after = 1'bx; busy_c1 = 1'bx; rst_busy = 1'bx; rst_write = 1'bx;
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == re_at);
      if (c == re_at) begin
        cfg_period = 16'hFFFF; cfg_compare1 = 16'hEEEE; cfg_prescale = 8'h77;
      end
      host_write      = (c >= h_from) && (c < h_from + h_len);
      host_addr       = host_write ? 6'h0A : 6'h00;
      host_data_write = host_write ? 8'h5A : 8'h00;
      if (rst_at > 0 && c == rst_at + 2) rst_n = 1'b1;
      if (c == rst_at) begin
        rst_n = 1'b0; #1;
        rst_busy = busy; rst_write = write; wr_at_rst = seq_wa.size();
      end
      @(negedge clk);
      if (c == 1) busy_c1 = busy;
      if (host_write) begin
        host_seen++;
        if (write && !read && addr == 6'h0A && data_write == 8'h5A) host_ok++;
      end else if (write) begin
        if (first_wr_cyc < 0) first_wr_cyc = c;
        seq_wa.push_back(addr); seq_wd.push_back(data_write);
      end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (c == done_cyc + 1) busy_after = busy;
    end
    host_write = 0; host_addr = 0; host_data_write = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; #12;
    checks++; if ({busy, done, error} !== 3'b000) begin errs++; $display("FAIL reset_status got=%b want=000", {busy, done, error}); end
    checks++; if ({read, write, addr, data_write} !== 16'h0) begin errs++; $display("FAIL reset_port got=%h want=0", {read, write, addr, data_write}); end
    host_write = 1; host_addr = 6'h05; host_data_write = 8'hC3; #1;
    checks++; if ({write, addr, data_write} !== {1'b1, 6'h05, 8'hC3}) begin errs++; $display("FAIL reset_passthru got=%h want=%h", {write, addr, data_write}, {1'b1, 6'h05, 8'hC3}); end
    host_write = 0; host_addr = 0; host_data_write = 0;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_basic;
    set_cfg(16'h1234, 16'h0400, 16'h0800, 8'h03, 1'b1, 8'h02);
    run_seq(40, 0, 0, 0, 0);
    checks++; if (first_wr_cyc !== 1) begin errs++; $display("FAIL first_write_cycle got=%0d want=1", first_wr_cyc); end
    checks++; if (busy_c1 !== 1'b1) begin errs++; $display("FAIL busy_cycle1 got=%b want=1", busy_c1); end
    checks++; if (seq_wa.size() !== 14) begin errs++; $display("FAIL write_count got=%0d want=14", seq_wa.size()); end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (seq_wa[i] !== exp_a[i] || seq_wd[i] !== exp_d[i]) begin
        errs++; $display("FAIL write_step%0d got=%h<-%h want=%h<-%h", i, seq_wa[i], seq_wd[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (done_cyc !== BASE_DONE) begin errs++; $display("FAIL done_cycle got=%0d want=%0d", done_cyc, BASE_DONE); end
    checks++; if (done_cnt !== 1) begin errs++; $display("FAIL done_count got=%0d want=1", done_cnt); end
    checks++; if (busy_after !== 1'b0) begin errs++; $display("FAIL busy_after_done got=%b want=0", busy_after); end
    checks++; if ({regs[0], regs[1], regs[3], regs[4], regs[5], regs[6]} !== 48'h3412_0004_0008) begin
      errs++; $display("FAIL regs_values got=%h want=341200040008", {regs[0], regs[1], regs[3], regs[4], regs[5], regs[6]}); end
    checks++; if ({regs[10], regs[11], regs[13]} !== 24'h030102) begin errs++; $display("FAIL regs_cfg got=%h want=030102", {regs[10], regs[11], regs[13]}); end
    checks++; if ({regs[2], regs[12], regs[7]} !== 24'h010101) begin errs++; $display("FAIL regs_enable got=%h want=010101", {regs[2], regs[12], regs[7]}); end
    checks++; if (error !== 1'b0) begin errs++; $display("FAIL basic_error got=%b want=0", error); end
  endtask

  task automatic test_host_read;
    host_read = 1; host_addr = 6'h01;
    @(posedge clk); #1;
    checks++; if (host_data_read !== 8'h12) begin errs++; $display("FAIL host_read_data got=%h want=12", host_data_read); end
    checks++; if ({read, write, addr} !== {1'b1, 1'b0, 6'h01}) begin errs++; $display("FAIL host_read_port got=%h want=%h", {read, write, addr}, {1'b1, 1'b0, 6'h01}); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL host_read_idle got=%b want=0", busy); end
    host_read = 0; host_addr = 0;
  endtask

  task automatic test_host_stall;
    set_cfg(16'h5678, 16'h0111, 16'h0222, 8'h09, 1'b0, 8'h01);
    run_seq(40, VERIFY ? 7 : 5, 3, 0, 0);
    checks++; if (host_ok !== 3 || host_seen !== 3) begin errs++; $display("FAIL host_passthru got=%0d/%0d want=3/3", host_ok, host_seen); end
    checks++; if (seq_wa.size() !== 14) begin errs++; $display("FAIL stall_write_count got=%0d want=14", seq_wa.size()); end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (seq_wa[i] !== exp_a[i] || seq_wd[i] !== exp_d[i]) begin
        errs++; $display("FAIL stall_step%0d got=%h<-%h want=%h<-%h", i, seq_wa[i], seq_wd[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (done_cyc !== BASE_DONE + 3) begin errs++; $display("FAIL stall_done_cycle got=%0d want=%0d", done_cyc, BASE_DONE + 3); end
    checks++; if (regs[10] !== 8'h09) begin errs++; $display("FAIL stall_prescale got=%h want=09", regs[10]); end
  endtask

  task automatic test_verify_fault;
    set_cfg(16'h1234, 16'h0400, 16'h0800, 8'h03, 1'b1, 8'h02);
    fault = 1'b1;
    run_seq(30, 0, 0, 0, 0);
    fault = 1'b0;
    checks++; if (error !== 1'b1) begin errs++; $display("FAIL fault_error got=%b want=1", error); end
    checks++; if (done_cyc !== 9 || done_cnt !== 1) begin errs++; $display("FAIL fault_done got=%0d x%0d want=9 x1", done_cyc, done_cnt); end
    checks++; if (seq_wa.size() !== 5) begin errs++; $display("FAIL fault_write_count got=%0d want=5", seq_wa.size()); end
    checks++; if ({regs[2], regs[12]} !== 16'h0000) begin errs++; $display("FAIL fault_enable got=%h want=0000", {regs[2], regs[12]}); end
  endtask

  task automatic test_back_to_back;
    set_cfg(16'h2468, 16'h0135, 16'h0246, 8'h05, 1'b1, 8'h03);
    run_seq(40, 0, 0, 5, 0);
    checks++; if (done_cnt !== 1 || done_cyc !== BASE_DONE) begin errs++; $display("FAIL b2b_done got=%0d x%0d want=%0d x1", done_cyc, done_cnt, BASE_DONE); end
    checks++; if ({regs[0], regs[1], regs[3], regs[10]} !== 32'h6824_3505) begin errs++; $display("FAIL b2b_latched got=%h want=68243505", {regs[0], regs[1], regs[3], regs[10]}); end
    checks++; if (error !== 1'b0) begin errs++; $display("FAIL b2b_error_cleared got=%b want=0", error); end
  endtask

  task automatic test_reset_mid;
    set_cfg(16'h0F0F, 16'h0101, 16'h0202, 8'h01, 1'b0, 8'h00);
    run_seq(30, 0, 0, 0, VERIFY ? 13 : 8);
    checks++; if (rst_busy !== 1'b0 || rst_write !== 1'b0) begin errs++; $display("FAIL rst_async got=%b%b want=00", rst_busy, rst_write); end
    checks++; if (wr_at_rst !== 7 || seq_wa.size() !== 7) begin errs++; $display("FAIL rst_no_writes got=%0d/%0d want=7/7", wr_at_rst, seq_wa.size()); end
    checks++; if (done_cnt !== 0 || busy !== 1'b0) begin errs++; $display("FAIL rst_idle got=%0d/%b want=0/0", done_cnt, busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_host_read;
    test_host_stall;
`ifdef PWM_CFG_SEQ_VERIFY_EN
    test_verify_fault;
`endif
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_seq.md
# pwm_cfg_seq

Configuration sequencer and bus arbiter in front of the PWM register file. On a single `start` pulse it safely reprograms a complete PWM profile (disable, load period/compares/prescale/direction/functions, reset counter, re-enable) through the register file's read/write port. It shares that port with the host-side decoder, giving the host strict priority. Optionally it reads back and verifies every data register it writes.

## Interface
Parameters:
- none. Register map addresses are fixed: 0x00–0x0D as in the register file.

Ports:
- `clk`  in  1  peripheral clock
- `rst_n`  in  1  asynchronous active-low reset
- `host_read`  in  1  decoder read request
- `host_write`  in  1  decoder write request
- `host_addr`  in  6  decoder address
- `host_data_write`  in  8  decoder write data
- `host_data_read`  out  8  read data to decoder; always equals `data_read`
- `start`  in  1  one-cycle request to run the sequence
- `cfg_period`  in  16  period to program
- `cfg_compare1`  in  16  compare1 to program
- `cfg_compare2`  in  16  compare2 to program
- `cfg_prescale`  in  8  prescale to program
- `cfg_upnotdown`  in  1  count direction to program
- `cfg_functions`  in  8  functions to program
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse when the sequence ends, whether it completes or aborts
- `error`  out  1  verify mismatch; sticky until next accepted `start`
- `read`, `write`  out  1  register-file strobes
- `addr`  out  6  register-file address
- `data_write`  out  8  register-file write data
- `data_read`  in  8  register-file read data (combinational from `addr`)

## Operation
- States: IDLE, WRITE, VERIFY, DONE. A 4-bit step index selects the current entry of the write list.
- Write list, in order (14 steps):
  - 0x02←0x00, 0x0C←0x00
  - 0x00←period[7:0], 0x01←period[15:8]
  - 0x03/0x04←compare1 low/high, 0x05/0x06←compare2 low/high
  - 0x0A←prescale, 0x0B←{7'b0,upnotdown}, 0x0D←functions
  - 0x07←0x01 (counter reset)
  - 0x0C←0x01, 0x02←0x01
- IDLE: `start` is accepted. All `cfg_*` inputs are latched, `error` is cleared, and the block enters WRITE at step 0.
- WRITE: drives `write=1` with the step's `addr` and `data_write`.
  - Data-register steps (0x00,01,03,04,05,06,0A,0B,0D) go to VERIFY when verify is compiled in.
  - All other steps go to the next step.
  - After step 13, go to DONE.
- VERIFY: drives `read=1` at the same address and compares `data_read` with the value just written.
  - On match: go to the next step.
  - On mismatch: set `error` and go to DONE, skipping the remaining steps, so the block is never re-enabled.
- DONE: pulses `done` for one cycle, then returns to IDLE.
- Arbitration, combinational: when `host_read|host_write` is high, the host owns the port.
  - `read`, `write`, `addr` and `data_write` pass the host values through.
  - The sequencer holds its state and step; its access is retried on the next free cycle.
  - The host may stall the sequence indefinitely; no fairness is provided.
- Idle port: when neither side is active, `read=write=0`, `addr=0`, `data_write=0`.
- `start` while `busy`: ignored. `start` in the same cycle as a host access is still accepted.
- `busy`: high in WRITE, VERIFY and DONE; low in IDLE.

## Timing
- Reset values: `busy=0`, `done=0`, `error=0`, state IDLE, step 0, latched cfg all zero. Port outputs follow the host inputs, or are 0.
- Reset mid-sequence returns to IDLE immediately; no further writes are issued.
- `start` is sampled at edge 0. The first write is driven in cycle 1.
- Uncontested latency, no verify: writes in cycles 1–14, `done` in cycle 15, `busy` low in cycle 16.
- Uncontested latency, with verify: 23 access cycles, `done` in cycle 24.
- Each cycle of host access adds exactly one cycle of latency.
- A VERIFY read occurs at least one edge after its write, so `data_read` reflects the new value.

## Configuration
- `PWM_CFG_SEQ_VERIFY_EN` defined: VERIFY state present, readback after each of the 9 data writes, `error` functional.
- `PWM_CFG_SEQ_VERIFY_EN` undefined: VERIFY state removed, `read` is driven only by the host, `error` is tied to 0, latency is 15 cycles to `done`.

## Test plan
- Reset, then `start` with period=0x1234, compare1=0x0400, compare2=0x0800, prescale=0x03, upnotdown=1, functions=0x02.
  - Required: the 14-step write sequence in order; the register file reads back those values; en=pwm_en=1.
  - Required: `done` in cycle 15, or cycle 24 with verify.
- Host write to 0x0A for 3 cycles starting at sequencer step 4.
  - Required: host values appear on the port in those cycles; the sequence resumes at step 4; `done` is 3 cycles late.
- With verify: force `data_read` to 0xFF on the 0x03 readback.
  - Required: `error=1`, `done` pulse; no writes to 0x07, 0x0C←1 or 0x02←1; en stays 0.
- `start` pulsed again while `busy`.
  - Required: ignored; a single `done`; the latched cfg is unchanged even if `cfg_*` changes mid-run.
- Assert `rst_n` low at step 7.
  - Required: `busy=0` asynchronously; no writes after release until a new `start`.
- Host read of 0x01 while idle.
  - Required: `host_data_read` equals the register contents; the sequencer stays in IDLE.
